// File: rtl/clmul_pkg.sv
// Shared constants, state encoding and slice-placement helpers for the
// carry-less product slice reducer.
package clmul_pkg;

  localparam int SLICE_W = 7;
  localparam int BEATS   = 3;
  localparam int FIELD_W = 8;
  localparam int ACC_W   = 2 * FIELD_W - 1;
  localparam int WIDE_W  = ACC_W + SLICE_W;
  localparam int BEAT_W  = 2;
  localparam int IDX_W   = 4;
  localparam logic [FIELD_W:0] POLY = 9'h11B;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    REDUCE  = 2'd1,
    OUT     = 2'd2
  } state_t;

  // Slice placed at its beat offset, at full width so nothing is lost before truncation.
  function automatic logic [WIDE_W-1:0] gf_place(input logic [SLICE_W-1:0] slice,
                                                 input logic [BEAT_W-1:0]  beat);
    return WIDE_W'(slice) << (int'(beat) * SLICE_W);
  endfunction

  // Accumulator with the slice XORed in at its beat offset, truncated to ACC_W.
  function automatic logic [ACC_W-1:0] gf_shift_xor(input logic [ACC_W-1:0]   acc,
                                                    input logic [SLICE_W-1:0] slice,
                                                    input logic [BEAT_W-1:0]  beat);
    logic [WIDE_W-1:0] wide;
    wide = gf_place(slice, beat);
    return acc ^ wide[ACC_W-1:0];
  endfunction

  // True when any slice bit lands at or above ACC_W and would be dropped.
  function automatic logic gf_shift_ovf(input logic [SLICE_W-1:0] slice,
                                        input logic [BEAT_W-1:0]  beat);
    logic [WIDE_W-1:0] wide;
    wide = gf_place(slice, beat);
    return |wide[WIDE_W-1:ACC_W];
  endfunction

endpackage

// File: rtl/gf_reduce_step.sv
// One modular-reduction step: clears bit idx_i of the accumulator by
// XORing in the field polynomial aligned so its x^8 term sits on that bit.
module gf_reduce_step
  import clmul_pkg::*;
(
  input  logic [ACC_W-1:0] acc_i,
  input  logic [IDX_W-1:0] idx_i,
  output logic [ACC_W-1:0] acc_o
);

  logic [IDX_W-1:0] shamt_s;
  logic [ACC_W-1:0] poly_s;

  // Conditional XOR of the shifted polynomial when the indexed bit is set.
  always_comb begin
    shamt_s = idx_i - IDX_W'(FIELD_W);
    poly_s  = ACC_W'(POLY) << shamt_s;
    if ((idx_i >= IDX_W'(FIELD_W)) && (idx_i < IDX_W'(ACC_W)) && acc_i[idx_i]) begin
      acc_o = acc_i ^ poly_s;
    end else begin
      acc_o = acc_i;
    end
  end

endmodule

// File: rtl/clmul_slice_reducer.sv
// Collects up to BEATS product slices into a carry-less accumulator,
// reduces it modulo POLY one bit per cycle and offers the field element
// on a valid/ready result port.
module clmul_slice_reducer
  import clmul_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               slice_valid,
  output logic               slice_ready,
  input  logic [SLICE_W-1:0] slice_data,
  input  logic               slice_last,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [FIELD_W-1:0] res_data,
  output logic               res_err
);

  state_t             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [BEAT_W-1:0]  beat_q, beat_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               ovf_q, ovf_d;
  logic               proto_q, proto_d;
  logic               slice_ready_q, slice_ready_d;
  logic               res_valid_q, res_valid_d;
  logic [FIELD_W-1:0] res_data_q, res_data_d;
  logic               res_err_q, res_err_d;
  logic [ACC_W-1:0]   step_acc_s;

  gf_reduce_step u_step (
    .acc_i (acc_q),
    .idx_i (idx_q),
    .acc_o (step_acc_s)
  );

  // Next-state logic for the collect / reduce / output sequence.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    beat_d      = beat_q;
    idx_d       = idx_q;
    ovf_d       = ovf_q;
    proto_d     = proto_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_err_d   = res_err_q;
    case (state_q)
      COLLECT: begin
        res_valid_d = 1'b0;
        if (slice_valid && slice_ready_q) begin
          acc_d  = gf_shift_xor(acc_q, slice_data, beat_q);
          ovf_d  = ovf_q | gf_shift_ovf(slice_data, beat_q);
          beat_d = beat_q + 2'd1;
          if (slice_last) begin
            state_d = REDUCE;
            idx_d   = IDX_W'(ACC_W - 1);
          end else if (beat_q == BEAT_W'(BEATS - 1)) begin
            // Ran out of beats without a last marker: finish anyway, flag it.
            state_d = REDUCE;
            idx_d   = IDX_W'(ACC_W - 1);
            proto_d = 1'b1;
          end else begin
            state_d = COLLECT;
          end
        end else begin
          state_d = COLLECT;
        end
      end
      REDUCE: begin
        acc_d = step_acc_s;
        if (idx_q == IDX_W'(FIELD_W)) begin
          state_d     = OUT;
          res_valid_d = 1'b1;
          res_data_d  = step_acc_s[FIELD_W-1:0];
          res_err_d   = ovf_q | proto_q;
        end else begin
          idx_d = idx_q - 4'd1;
        end
      end
      OUT: begin
        if (res_ready) begin
          state_d     = COLLECT;
          res_valid_d = 1'b0;
          acc_d       = '0;
          beat_d      = '0;
          idx_d       = '0;
          ovf_d       = 1'b0;
          proto_d     = 1'b0;
        end else begin
          state_d = OUT;
        end
      end
      default: begin
        state_d     = COLLECT;
        res_valid_d = 1'b0;
      end
    endcase
    slice_ready_d = (state_d == COLLECT);
  end

  // State, datapath and registered-output update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= COLLECT;
      acc_q         <= '0;
      beat_q        <= '0;
      idx_q         <= '0;
      ovf_q         <= 1'b0;
      proto_q       <= 1'b0;
      slice_ready_q <= 1'b0;
      res_valid_q   <= 1'b0;
      res_data_q    <= '0;
      res_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      acc_q         <= acc_d;
      beat_q        <= beat_d;
      idx_q         <= idx_d;
      ovf_q         <= ovf_d;
      proto_q       <= proto_d;
      slice_ready_q <= slice_ready_d;
      res_valid_q   <= res_valid_d;
      res_data_q    <= res_data_d;
      res_err_q     <= res_err_d;
    end
  end

  assign slice_ready = slice_ready_q;
  assign res_valid   = res_valid_q;
  assign res_data    = res_data_q;
  assign res_err     = res_err_q;

endmodule
